// File: rtl/cchw_pkg.sv
// Constants and types shared by the filter bank and the bin peak reader.
package cchw_pkg;

  localparam int N_DEF    = 16;
  localparam int BINS_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bin_peak_reader.sv
// Scans the filtered bin store circularly and streams local maxima above a
// threshold over a single-slot valid/ready output.
module bin_peak_reader
  import cchw_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int BINS = BINS_DEF,
  localparam int AW   = $clog2(BINS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] threshold,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic signed [N-1:0] rd_data,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic [AW-1:0]       peak_bin,
  output logic signed [N-1:0] peak_value,
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);

  // Handshake: a peak record transfers on any edge where peak_valid && peak_ready;
  // the record is held stable while peak_valid is high and peak_ready is low.

  localparam int NREADS = BINS + 2;
  localparam int CW     = $clog2(NREADS + 1);
  localparam logic [CW-1:0] LAST_RD  = CW'(NREADS);
  localparam logic [CW-1:0] FINAL_IX = CW'(NREADS - 1);
  localparam logic [AW-1:0] TOP_BIN  = AW'(BINS - 1);

  state_e state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] arr_cnt_q, arr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_vld_q;
  logic signed [N-1:0] thr_q, thr_d;
  logic signed [N-1:0] win_l_q, win_l_d;
  logic signed [N-1:0] win_c_q, win_c_d;
  logic                pv_q, pv_d;
  logic [AW-1:0]       pbin_q, pbin_d;
  logic signed [N-1:0] pval_q, pval_d;

  logic reads_left, eval, last_arr, peak_load, handshake, rd_go;

  // The arriving word is the right neighbour; the two registers hold left and centre.
  assign handshake  = pv_q && peak_ready;
  assign reads_left = rd_cnt_q < LAST_RD;
  assign eval       = rd_vld_q && (arr_cnt_q >= CW'(2));
  assign last_arr   = rd_vld_q && (arr_cnt_q == FINAL_IX);
  assign peak_load  = eval && (win_c_q > thr_q) && (win_c_q > win_l_q)
                      && (win_c_q >= rd_data);
  assign rd_go      = (state_q == SCAN) && reads_left
                      && !(pv_q && !peak_ready) && !peak_load;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    arr_cnt_d = arr_cnt_q;
    rd_addr_d = rd_addr_q;
    thr_d     = thr_q;
    win_l_d   = win_l_q;
    win_c_d   = win_c_q;
    pv_d      = pv_q;
    pbin_d    = pbin_q;
    pval_d    = pval_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          thr_d     = threshold;
          rd_cnt_d  = '0;
          arr_cnt_d = '0;
          rd_addr_d = TOP_BIN;
        end
      end
      SCAN: begin
        if (last_arr) state_d = (peak_load || (pv_q && !peak_ready)) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (!pv_q || peak_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The final read (bin 0 again) leaves the address parked on that bin.
    if (rd_go) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q != FINAL_IX) rd_addr_d = (rd_addr_q == TOP_BIN) ? '0 : rd_addr_q + 1'b1;
    end

    if (rd_vld_q) begin
      arr_cnt_d = arr_cnt_q + 1'b1;
      win_l_d   = win_c_q;
      win_c_d   = rd_data;
    end

    if (peak_load) begin
      pv_d   = 1'b1;
      pbin_d = AW'(arr_cnt_q - CW'(2));
      pval_d = win_c_q;
    end else if (handshake) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      arr_cnt_q <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      thr_q     <= '0;
      win_l_q   <= '0;
      win_c_q   <= '0;
      pv_q      <= 1'b0;
      pbin_q    <= '0;
      pval_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      arr_cnt_q <= arr_cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_go;
      thr_q     <= thr_d;
      win_l_q   <= win_l_d;
      win_c_q   <= win_c_d;
      pv_q      <= pv_d;
      pbin_q    <= pbin_d;
      pval_q    <= pval_d;
    end
  end

  assign rd_en      = rd_go;
  assign rd_addr    = rd_addr_q;
  assign peak_valid = pv_q;
  assign peak_bin   = pbin_q;
  assign peak_value = pval_q;
  assign busy       = (state_q == SCAN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bin_peak_reader.sv
// Directed and random scans of bin_peak_reader against a circular peak model
// and a registered bin store that answers one cycle after rd_en.
module tb_bin_peak_reader;
  import cchw_pkg::*;

  localparam int N    = 16;
  localparam int BINS = 24;
  localparam int AW   = $clog2(BINS);

  logic clk = 1'b0;
  logic rst;
  logic start = 1'b0;
  logic peak_ready = 1'b0;
  logic signed [N-1:0] threshold = '0;
  logic signed [N-1:0] rd_data = '0;
  logic rd_en, peak_valid, busy, done;
  logic [AW-1:0] rd_addr, peak_bin;
  logic signed [N-1:0] peak_value;
  state_e dbg_state;

  logic signed [N-1:0] mem [BINS];
  logic [AW+N-1:0] exp_q[$];
  logic [AW-1:0]   addr_q[$];

  int total = 0, bad = 0;
  int cyc = 0, rd_en_cnt = 0, done_cnt = 0, done_cyc = 0, hs_cnt = 0;

  bin_peak_reader #(.N(N), .BINS(BINS)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .peak_valid(peak_valid), .peak_ready(peak_ready),
    .peak_bin(peak_bin), .peak_value(peak_value),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / bin store
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: read addresses and peak records popped as the DUT produces them
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en) begin
        rd_en_cnt++;
        if (addr_q.size() == 0) check("rd_extra", addr_q.size(), 1);
        else check("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (peak_valid && peak_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("peak_extra", exp_q.size(), 1);
        else check("peak_rec", {peak_bin, peak_value}, exp_q.pop_front());
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < BINS; i++) mem[i] = '0;
  endtask

  task automatic load_expect(input logic signed [N-1:0] thr);
    logic signed [N-1:0] l, m, r;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < BINS + 2; k++) addr_q.push_back(AW'((k + BINS - 1) % BINS));
    for (int c = 0; c < BINS; c++) begin
      l = mem[(c + BINS - 1) % BINS];
      m = mem[c];
      r = mem[(c + 1) % BINS];
      if (m > thr && m > l && m >= r) exp_q.push_back({AW'(c), m});
    end
  endtask

  task automatic run_scan(input logic signed [N-1:0] thr, input string tag);
    int s_cyc, npk, d0, r0;
    load_expect(thr);
    npk = exp_q.size();
    d0 = done_cnt;
    r0 = rd_en_cnt;
    threshold = thr;
    start = 1'b1;
    s_cyc = cyc;
    step();
    start = 1'b0;
    threshold = $urandom_range(0, 255);
    check({tag, "_busy"}, busy, 1);
    for (int i = 0; i < 400 && done_cnt == d0; i++) step();
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_latency"}, done_cyc - s_cyc - 1, BINS + 3 + npk);
    check({tag, "_rd_count"}, rd_en_cnt - r0, BINS + 2);
    check({tag, "_peaks_left"}, exp_q.size(), 0);
    check({tag, "_done_pulse"}, done, 0);
    step();
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0, d0, v;
    rst = 1'b0;
    peak_ready = 1'b1;
    clear_mem();
    repeat (3) step();
    check("rst_rd_en", rd_en, 0);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_peak", {peak_bin, peak_value}, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    step();

    run_scan(16'sd0, "zeros");

    clear_mem();
    for (int i = 0; i < BINS; i++) mem[i] = 16'sd10;
    mem[5] = 16'sd100;
    mem[6] = 16'sd40;
    run_scan(16'sd20, "single");

    clear_mem();
    mem[0] = 16'sd50;
    mem[23] = 16'sd60;
    mem[1] = 16'sd5;
    run_scan(16'sd0, "wrap");

    clear_mem();
    mem[8] = 16'sd70;
    mem[9] = 16'sd70;
    mem[10] = 16'sd70;
    run_scan(16'sd0, "plateau");

    clear_mem();
    mem[4] = -16'sd5;
    mem[7] = -16'sd3;
    mem[8] = -16'sd9;
    run_scan(-16'sd6, "negative");

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < BINS; i++) begin
        v = int'($urandom_range(0, 200)) - 100;
        mem[i] = v[N-1:0];
      end
      v = int'($urandom_range(0, 40)) - 20;
      run_scan(v[N-1:0], "random");
    end

    // backpressure on the first peak
    clear_mem();
    mem[3] = 16'sd80;
    mem[12] = 16'sd90;
    load_expect(16'sd10);
    peak_ready = 1'b0;
    h0 = hs_cnt;
    d0 = done_cnt;
    threshold = 16'sd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !peak_valid; i++) step();
    check("bp_valid_seen", peak_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_rd_en_low", rd_en, 0);
      check("bp_hold", {peak_valid, peak_bin, peak_value}, {1'b1, AW'(3), 16'sd80});
      check("bp_no_done", done_cnt - d0, 0);
      step();
    end
    peak_ready = 1'b1;
    for (int i = 0; i < 400 && done_cnt == d0; i++) step();
    check("bp_done_cnt", done_cnt - d0, 1);
    check("bp_handshakes", hs_cnt - h0, 2);
    check("bp_peaks_left", exp_q.size(), 0);
    step();

    // reset while reading bin 7
    clear_mem();
    mem[10] = 16'sd55;
    load_expect(16'sd0);
    threshold = 16'sd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !(rd_en && rd_addr == AW'(7)); i++) step();
    check("mid_at_bin7", {rd_en, rd_addr}, {1'b1, AW'(7)});
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    check("mid_rd_en", rd_en, 0);
    check("mid_rd_addr", rd_addr, 0);
    check("mid_peak", {peak_valid, peak_bin, peak_value}, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_state", dbg_state, IDLE);
    repeat (3) step();
    check("mid_no_done", done_cnt - d0, 0);
    exp_q.delete();
    addr_q.delete();
    rst = 1'b1;
    step();
    run_scan(16'sd0, "rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
